// File: rtl/router_input_port.sv
// Input stage of one NoC router port. Flits are buffered in a small FIFO.
// Each head flit is routed XY, and a one-hot request toward the output
// arbiters is held from the head flit to the tail flit.
module router_input_port #(
  parameter int FLIT_W    = 34,
  parameter int DEPTH     = 4,
  parameter int DST_X_LSB = 26,
  parameter int DST_Y_LSB = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        local_x,
  input  logic [2:0]        local_y,
  input  logic [FLIT_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [FLIT_W-1:0] data_out,
  output logic [4:0]        request,
  input  logic              forwarded,
  output logic              forwarding_head,
  output logic              forwarding_tail,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One-hot output port encoding.
  localparam logic [4:0] REQ_N = 5'b00001;
  localparam logic [4:0] REQ_S = 5'b00010;
  localparam logic [4:0] REQ_W = 5'b00100;
  localparam logic [4:0] REQ_E = 5'b01000;
  localparam logic [4:0] REQ_L = 5'b10000;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [4:0]       route_q, route_d;
  logic             proto_err_q, proto_err_d;

  logic [FLIT_W-1:0] front;
  logic              empty;
  logic              full;
  logic              front_head;
  logic              front_tail;
  logic [4:0]        front_route;
  logic              discard;
  logic              push;
  logic              pop;

  // XY routing: resolve x first, then y, otherwise deliver locally.
  function automatic logic [4:0] xy_route(input logic [2:0] dst_x,
                                          input logic [2:0] dst_y,
                                          input logic [2:0] cur_x,
                                          input logic [2:0] cur_y);
    if (dst_x > cur_x)      return REQ_E;
    else if (dst_x < cur_x) return REQ_W;
    else if (dst_y < cur_y) return REQ_N;
    else if (dst_y > cur_y) return REQ_S;
    else                    return REQ_L;
  endfunction

  assign front       = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign front_head  = front[FLIT_W-1];
  assign front_tail  = front[FLIT_W-2];
  assign front_route = xy_route(front[DST_X_LSB +: 3], front[DST_Y_LSB +: 3],
                                local_x, local_y);

  // A non-head flit reaching the front between packets is dropped on the spot.
  assign discard = (state_q == IDLE) && !empty && !front_head;

  // A full FIFO refuses data even when it is being drained the same cycle.
  assign data_in_ready   = !full;
  assign push            = data_in_valid && !full;
  assign pop             = !empty && (forwarded || discard);
  assign data_out        = front;
  assign forwarding_head = forwarded && !empty && front_head;
  assign forwarding_tail = forwarded && !empty && front_tail;
  assign proto_err       = proto_err_q;

  // Request: live route of a head in IDLE, latched packet route in BODY.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    request = '0;
    if (!empty) begin
      if (state_q == BODY)  request = route_q;
      else if (front_head)  request = front_route;
    end
  end

  // Next-state for FIFO pointers, occupancy, packet FSM and the error flag.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    route_d     = route_q;
    proto_err_d = proto_err_q | discard;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (forwarded && !empty && front_head && !front_tail) begin
          route_d = front_route;
          state_d = BODY;
        end
      end
      BODY: begin
        if (forwarded && !empty && front_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      route_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      route_q     <= route_d;
      proto_err_q <= proto_err_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read after it has been written, as tracked by count_q.
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_router_input_port.sv
// Directed self-checking bench for router_input_port.
module tb_router_input_port;

  localparam int FLIT_W = 34;

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_W = 5'b00100;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        local_x;
  logic [2:0]        local_y;
  logic [FLIT_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [FLIT_W-1:0] data_out;
  logic [4:0]        request;
  logic              forwarded;
  logic              forwarding_head;
  logic              forwarding_tail;
  logic              proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  router_input_port dut (
    .clk             (clk),
    .rst             (rst),
    .local_x         (local_x),
    .local_y         (local_y),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready),
    .data_out        (data_out),
    .request         (request),
    .forwarded       (forwarded),
    .forwarding_head (forwarding_head),
    .forwarding_tail (forwarding_tail),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FLIT_W-1:0] mk(input logic h, input logic t,
                                           input logic [2:0] dx, input logic [2:0] dy,
                                           input logic [25:0] pl);
    logic [FLIT_W-1:0] f;
    f        = '0;
    f[33]    = h;
    f[32]    = t;
    f[31:29] = dy;
    f[28:26] = dx;
    f[25:0]  = pl;
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [FLIT_W-1:0] exp_flit;

  initial begin
    rst = 1'b1; local_x = 3'd2; local_y = 3'd2;
    data_in = '0; data_in_valid = 1'b0; forwarded = 1'b0;
    step(); step();
    #1;
    check("rst_request", 64'(request), 64'(5'b0));
    check("rst_ready",   64'(data_in_ready), 64'(1'b1));
    check("rst_fhead",   64'(forwarding_head), 64'(1'b0));
    check("rst_ftail",   64'(forwarding_tail), 64'(1'b0));
    check("rst_perr",    64'(proto_err), 64'(1'b0));
    rst = 1'b0;

    // 1. Single-flit packet, local (2,2), dst (3,2) -> East.
    step();
    data_in = mk(1'b1, 1'b1, 3'd3, 3'd2, 26'h11); data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0; #1;
    check("t1_req_e", 64'(request), 64'(R_E));
    forwarded = 1'b1; #1;
    check("t1_fhead", 64'(forwarding_head), 64'(1'b1));
    check("t1_ftail", 64'(forwarding_tail), 64'(1'b1));
    step();
    forwarded = 1'b0; #1;
    check("t1_req_done", 64'(request), 64'(5'b0));

    // 2. Four-flit packet, local (1,1), dst (1,0) -> North, with a bubble.
    local_x = 3'd1; local_y = 3'd1;
    data_in = mk(1'b1, 1'b0, 3'd1, 3'd0, 26'h20); data_in_valid = 1'b1;
    step();
    data_in = mk(1'b0, 1'b0, 3'd5, 3'd5, 26'h21);
    step();
    data_in_valid = 1'b0; #1;
    check("t2_req_h", 64'(request), 64'(R_N));
    forwarded = 1'b1; #1;
    check("t2_fhead_h", 64'(forwarding_head), 64'(1'b1));
    check("t2_ftail_h", 64'(forwarding_tail), 64'(1'b0));
    step();
    #1;
    check("t2_req_b1", 64'(request), 64'(R_N));
    check("t2_ftail_b1", 64'(forwarding_tail), 64'(1'b0));
    step();
    forwarded = 1'b0; #1;
    check("t2_req_bubble", 64'(request), 64'(5'b0));
    check("t2_state_body", 64'(dut.state_q), 64'(1'b1));
    data_in = mk(1'b0, 1'b0, 3'd0, 3'd0, 26'h22); data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0; #1;
    check("t2_req_b2", 64'(request), 64'(R_N));
    forwarded = 1'b1;
    data_in = mk(1'b0, 1'b1, 3'd7, 3'd7, 26'h23); data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0; #1;
    check("t2_req_t", 64'(request), 64'(R_N));
    check("t2_ftail_t", 64'(forwarding_tail), 64'(1'b1));
    check("t2_fhead_t", 64'(forwarding_head), 64'(1'b0));
    step();
    forwarded = 1'b0; #1;
    check("t2_req_end", 64'(request), 64'(5'b0));
    check("t2_state_idle", 64'(dut.state_q), 64'(1'b0));

    // 3. Fill the FIFO, then push+pop while full. local (1,1), dst (2,1) -> East.
    for (int i = 0; i < 4; i++) begin
      data_in = mk(i == 0, i == 3, 3'd2, 3'd1, 26'(32'h30 + i)); data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0; #1;
      check("t3_ready_fill", 64'(data_in_ready), 64'(i < 3));
    end
    check("t3_req_full", 64'(request), 64'(R_E));
    data_in = mk(1'b1, 1'b1, 3'd0, 3'd0, 26'h3f); data_in_valid = 1'b1; forwarded = 1'b1; #1;
    check("t3_fhead_full", 64'(forwarding_head), 64'(1'b1));
    step();
    data_in_valid = 1'b0; forwarded = 1'b0; #1;
    check("t3_ready_after", 64'(data_in_ready), 64'(1'b1));
    check("t3_count_3", 64'(dut.count_q), 64'(3));
    check("t3_req_body", 64'(request), 64'(R_E));
    forwarded = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      exp_flit = mk(1'b0, i == 3, 3'd2, 3'd1, 26'(32'h30 + i));
      check("t3_drain_data", 64'(data_out), 64'(exp_flit));
      check("t3_drain_ftail", 64'(forwarding_tail), 64'(i == 3));
      step();
    end
    forwarded = 1'b0; #1;
    check("t3_count_0", 64'(dut.count_q), 64'(0));
    check("t3_req_end", 64'(request), 64'(5'b0));

    // 4. Pointer wrap: 10 single-flit packets, forwarded held high. local (2,2) -> Local.
    local_x = 3'd2; local_y = 3'd2;
    forwarded = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = mk(1'b1, 1'b1, 3'd2, 3'd2, 26'(32'h40 + i)); data_in_valid = 1'b1; #1;
      check("t4_count", 64'(dut.count_q), 64'((i == 0) ? 0 : 1));
      if (i > 0) begin
        exp_flit = mk(1'b1, 1'b1, 3'd2, 3'd2, 26'(32'h40 + i - 1));
        check("t4_data", 64'(data_out), 64'(exp_flit));
        check("t4_req", 64'(request), 64'(R_L));
      end
      step();
    end
    data_in_valid = 1'b0; #1;
    exp_flit = mk(1'b1, 1'b1, 3'd2, 3'd2, 26'h49);
    check("t4_data_last", 64'(data_out), 64'(exp_flit));
    step();
    forwarded = 1'b0; #1;
    check("t4_count_end", 64'(dut.count_q), 64'(0));

    // 5. Protocol error: stray body flit in IDLE is dropped and flagged.
    data_in = mk(1'b0, 1'b0, 3'd3, 3'd3, 26'h50); data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0; #1;
    check("t5_req_stray", 64'(request), 64'(5'b0));
    step();
    #1;
    check("t5_perr_set", 64'(proto_err), 64'(1'b1));
    check("t5_count_drop", 64'(dut.count_q), 64'(0));
    data_in = mk(1'b1, 1'b1, 3'd1, 3'd2, 26'h51); data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0; #1;
    check("t5_req_w", 64'(request), 64'(R_W));
    forwarded = 1'b1;
    step();
    forwarded = 1'b0; #1;
    check("t5_perr_sticky", 64'(proto_err), 64'(1'b1));
    check("t5_req_end", 64'(request), 64'(5'b0));

    // 6. Reset mid-packet. local (1,1), dst (1,2) -> South.
    local_x = 3'd1; local_y = 3'd1;
    data_in = mk(1'b1, 1'b0, 3'd1, 3'd2, 26'h60); data_in_valid = 1'b1;
    step();
    data_in = mk(1'b0, 1'b0, 3'd0, 3'd0, 26'h61);
    step();
    data_in = mk(1'b0, 1'b0, 3'd0, 3'd0, 26'h62); forwarded = 1'b1;
    step();
    data_in_valid = 1'b0; forwarded = 1'b0; #1;
    check("t6_req_body", 64'(request), 64'(R_S));
    check("t6_count_2", 64'(dut.count_q), 64'(2));
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    check("t6_req_rst", 64'(request), 64'(5'b0));
    check("t6_ready_rst", 64'(data_in_ready), 64'(1'b1));
    check("t6_perr_rst", 64'(proto_err), 64'(1'b0));
    data_in = mk(1'b1, 1'b1, 3'd0, 3'd1, 26'h63); data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0; #1;
    check("t6_req_w", 64'(request), 64'(R_W));
    forwarded = 1'b1; #1;
    check("t6_fhead", 64'(forwarding_head), 64'(1'b1));
    step();
    forwarded = 1'b0; #1;
    check("t6_req_end", 64'(request), 64'(5'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
